// File: rtl/dram_port_arbiter_pkg.sv
// Shared types for the data-RAM port arbiter: FSM states and requester ids.
package dram_arb_pkg;

    typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} arb_state_e;
    typedef enum logic {M0 = 1'b0, M1 = 1'b1} req_id_e;

    function automatic logic [1:0] id_onehot(input req_id_e id);
        return (id == M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// One requester port of the data-RAM arbiter (request, write data, grant, read return).
interface dram_port_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, on a tie the one not served last wins.
module rr_arbiter2
    import dram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    rr_last,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = (rr_last == M0) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the single-port data RAM between the CPU (m0) and the loader/debug port (m1).
//   state   | meaning
//   IDLE    | arbitrating; grants and RAM strobe are combinational this cycle
//   RD_WAIT | one read outstanding; lat_cnt counts down to the data-valid cycle
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    dram_port_arbiter_if.slave  m0,
    dram_port_arbiter_if.slave  m1,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e       state;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] lat_dec;
    req_id_e          rr_last;
    req_id_e          owner;
    logic [1:0]       pick;
    logic [1:0]       gnt;
    logic [1:0]       rvalid_q;
    logic             unused_addr_bits;

    rr_arbiter2 u_rr (
        .req     ({m1.req, m0.req}),
        .rr_last (rr_last),
        .pick    (pick)
    );

    assign gnt     = (state == IDLE) ? pick : 2'b00;
    assign m0.gnt  = gnt[0];
    assign m1.gnt  = gnt[1];
    assign lat_dec = lat_cnt - 1'b1;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt[0]) begin
            ram_en    = 1'b1;
            ram_we    = m0.we;
            ram_addr  = m0.addr[ADDR_W+1:2];
            ram_wdata = m0.wdata;
        end else if (gnt[1]) begin
            ram_en    = 1'b1;
            ram_we    = m1.we;
            ram_addr  = m1.addr[ADDR_W+1:2];
            ram_wdata = m1.wdata;
        end
    end

    // rvalid is registered one cycle ahead so it is high exactly while lat_cnt==1
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            owner    <= M0;
            rr_last  <= M1;
            rvalid_q <= 2'b00;
        end else begin
            rvalid_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        rr_last <= gnt[1] ? M1 : M0;
                        if (!ram_we) begin
                            state   <= RD_WAIT;
                            lat_cnt <= LAT_LOAD;
                            owner   <= gnt[1] ? M1 : M0;
                            if (LAT_LOAD == CNT_ONE) rvalid_q <= gnt;
                        end
                    end
                end
                RD_WAIT: begin
                    lat_cnt <= lat_dec;
                    if (lat_dec == CNT_ONE) rvalid_q <= id_onehot(owner);
                    if (lat_cnt == CNT_ONE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0.rvalid = rvalid_q[0];
    assign m1.rvalid = rvalid_q[1];
    assign m0.rdata  = rvalid_q[0] ? ram_rdata : '0;
    assign m1.rdata  = rvalid_q[1] ? ram_rdata : '0;

    // upper byte-address bits alias onto the RAM by design
    assign unused_addr_bits = ^{m0.addr[31:ADDR_W+2], m0.addr[1:0],
                                m1.addr[31:ADDR_W+2], m1.addr[1:0]};

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: two DUTs (RD_LAT=1 and RD_LAT=3), each with a RAM model.
module tb_dram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]             rst;
    logic [1:0][1:0]        req;
    logic [1:0][1:0]        we;
    logic [1:0][1:0][31:0]  addr;
    logic [1:0][1:0][31:0]  wdata;
    logic [1:0][1:0]        gnt_o;
    logic [1:0][1:0]        rv_o;
    logic [1:0][1:0][31:0]  rd_o;
    logic [1:0]             en_o;
    logic [1:0]             rwe_o;
    logic [1:0][11:0]       ra_o;
    logic [1:0][31:0]       rwd_o;

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        dram_port_arbiter_if #(.DATA_W(32)) m0_if ();
        dram_port_arbiter_if #(.DATA_W(32)) m1_if ();
        logic        ram_en, ram_we;
        logic [11:0] ram_addr;
        logic [31:0] ram_wdata, ram_rdata;
        logic [31:0] mem  [4096];
        logic [31:0] pipe [LAT];

        assign m0_if.req   = req[g][0];
        assign m0_if.we    = we[g][0];
        assign m0_if.addr  = addr[g][0];
        assign m0_if.wdata = wdata[g][0];
        assign m1_if.req   = req[g][1];
        assign m1_if.we    = we[g][1];
        assign m1_if.addr  = addr[g][1];
        assign m1_if.wdata = wdata[g][1];
        assign gnt_o[g]    = {m1_if.gnt, m0_if.gnt};
        assign rv_o[g]     = {m1_if.rvalid, m0_if.rvalid};
        assign rd_o[g]     = {m1_if.rdata, m0_if.rdata};
        assign en_o[g]     = ram_en;
        assign rwe_o[g]    = ram_we;
        assign ra_o[g]     = ram_addr;
        assign rwd_o[g]    = ram_wdata;

        dram_port_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(LAT)) u_dut (
            .cpu_clk   (clk),
            .cpu_rst   (rst[g]),
            .m0        (m0_if),
            .m1        (m1_if),
            .ram_en    (ram_en),
            .ram_we    (ram_we),
            .ram_addr  (ram_addr),
            .ram_wdata (ram_wdata),
            .ram_rdata (ram_rdata)
        );

        // synchronous RAM with LAT-cycle read pipeline
        always @(posedge clk) begin
            if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
            pipe[0] <= mem[ram_addr];
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign ram_rdata = pipe[LAT-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int g);
        rst[g] = 1'b1;
        req[g] = '0;
        repeat (3) tick();
        rst[g] = 1'b0;
    endtask

    task automatic chk_idle(input int g, input string tag);
        chk({tag, "_gnt"}, 32'(gnt_o[g]), 32'd0);
        chk({tag, "_rvalid"}, 32'(rv_o[g]), 32'd0);
        chk({tag, "_ram_en"}, 32'(en_o[g]), 32'd0);
        chk({tag, "_ram_we"}, 32'(rwe_o[g]), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ra_o[g]), 32'd0);
        chk({tag, "_ram_wdata"}, rwd_o[g], 32'd0);
        chk({tag, "_rdata0"}, rd_o[g][0], 32'd0);
        chk({tag, "_rdata1"}, rd_o[g][1], 32'd0);
    endtask

    // Reference: memory as associative array, one read outstanding tracked by its due cycle.
    task automatic run_random(input int g, input int lat, input int ncyc);
        logic [31:0] rmem [int];
        int          last_id, due, owner, k, w;
        logic [31:0] exp_rd;
        logic        exp_known;
        logic [1:0]  exp_g, exp_rv;
        last_id = 1; due = -1; owner = 0; k = 0;
        exp_rd = '0; exp_known = 1'b0;
        do_reset(g);
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[g][i] && c < ncyc - 12 && $urandom_range(0, 2) != 0) begin
                    req[g][i]   = 1'b1;
                    we[g][i]    = 1'($urandom_range(0, 1));
                    addr[g][i]  = ($urandom() & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
                    wdata[g][i] = $urandom();
                end
            end
            #2;
            exp_g = 2'b00;
            if (c > due) begin
                if (req[g] == 2'b11) exp_g = (last_id == 0) ? 2'b10 : 2'b01;
                else exp_g = req[g];
            end
            chk("rnd_gnt", 32'(gnt_o[g]), 32'(exp_g));
            exp_rv = (c == due) ? ((owner == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk("rnd_rvalid", 32'(rv_o[g]), 32'(exp_rv));
            if (c == due && exp_known) chk("rnd_rdata", rd_o[g][owner], exp_rd);
            chk("rnd_ram_en", 32'(en_o[g]), 32'(|exp_g));
            if (exp_g != 2'b00) begin
                k = exp_g[1] ? 1 : 0;
                w = int'(addr[g][k][13:2]);
                chk("rnd_ram_we", 32'(rwe_o[g]), 32'(we[g][k]));
                chk("rnd_ram_addr", 32'(ra_o[g]), 32'(addr[g][k][13:2]));
                last_id = k;
                if (we[g][k]) begin
                    chk("rnd_ram_wdata", rwd_o[g], wdata[g][k]);
                    rmem[w] = wdata[g][k];
                end else begin
                    due       = c + lat;
                    owner     = k;
                    exp_known = rmem.exists(w);
                    exp_rd    = exp_known ? rmem[w] : '0;
                end
            end
            tick();
            if (exp_g != 2'b00) req[g][k] = 1'b0;
        end
        req[g] = '0;
    endtask

    initial begin
        rst = 2'b11; req = '0; we = '0; addr = '0; wdata = '0;

        // reset and idle
        tick();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk_idle(0, "rst0");
            chk_idle(1, "rst1");
            tick();
        end
        rst = 2'b00;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("idle_en0", 32'(en_o[0]), 32'd0);
            chk("idle_en1", 32'(en_o[1]), 32'd0);
            tick();
        end

        run_random(0, 1, 400);
        run_random(1, 3, 400);

        // m0 write then read back, RD_LAT=1
        do_reset(0);
        req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 32'h40; wdata[0][0] = 32'hDEAD_BEEF;
        #2;
        chk("t2_w_gnt", 32'(gnt_o[0]), 32'h1);
        chk("t2_w_en", 32'(en_o[0]), 32'h1);
        chk("t2_w_we", 32'(rwe_o[0]), 32'h1);
        chk("t2_w_addr", 32'(ra_o[0]), 32'h10);
        chk("t2_w_wdata", rwd_o[0], 32'hDEAD_BEEF);
        tick();
        we[0][0] = 1'b0;
        #2;
        chk("t2_r_gnt", 32'(gnt_o[0]), 32'h1);
        chk("t2_r_we", 32'(rwe_o[0]), 32'h0);
        tick();
        req[0][0] = 1'b0;
        #2;
        chk("t2_rvalid", 32'(rv_o[0]), 32'h1);
        chk("t2_rdata", rd_o[0][0], 32'hDEAD_BEEF);
        tick();
        #2;
        chk("t2_rvalid_pulse", 32'(rv_o[0]), 32'h0);
        tick();

        // contention, both reading continuously
        do_reset(0);
        req[0] = 2'b11; we[0] = 2'b00; addr[0][0] = 32'h10; addr[0][1] = 32'h20;
        for (int c = 0; c < 8; c++) begin
            #2;
            chk("t3_gnt", 32'(gnt_o[0]), (c % 2 == 1) ? 32'h0 : ((c % 4 == 0) ? 32'h1 : 32'h2));
            chk("t3_rvalid", 32'(rv_o[0]), (c % 2 == 0) ? 32'h0 : ((c % 4 == 1) ? 32'h1 : 32'h2));
            tick();
        end
        req[0] = 2'b00;
        repeat (2) tick();

        // read latency 3
        do_reset(1);
        req[1][1] = 1'b1; we[1][1] = 1'b1; addr[1][1] = 32'h8; wdata[1][1] = 32'h1234_5678;
        #2;
        chk("t4_w_gnt", 32'(gnt_o[1]), 32'h2);
        tick();
        we[1][1] = 1'b0;
        #2;
        chk("t4_r_gnt", 32'(gnt_o[1]), 32'h2);
        tick();
        req[1][1] = 1'b0; req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 32'h40;
        for (int i = 1; i <= 2; i++) begin
            #2;
            chk("t4_wait_gnt", 32'(gnt_o[1]), 32'h0);
            chk("t4_wait_rvalid", 32'(rv_o[1]), 32'h0);
            tick();
        end
        #2;
        chk("t4_t3_gnt", 32'(gnt_o[1]), 32'h0);
        chk("t4_t3_rvalid", 32'(rv_o[1]), 32'h2);
        chk("t4_t3_rdata", rd_o[1][1], 32'h1234_5678);
        tick();
        #2;
        chk("t4_t4_gnt", 32'(gnt_o[1]), 32'h1);
        chk("t4_t4_rvalid", 32'(rv_o[1]), 32'h0);
        tick();
        req[1][0] = 1'b0;
        repeat (4) tick();

        // reset in the middle of a read
        do_reset(1);
        req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 32'h8;
        #2;
        chk("t5_gnt", 32'(gnt_o[1]), 32'h2);
        tick();
        req[1][1] = 1'b0; rst[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            chk("t5_no_rvalid", 32'(rv_o[1]), 32'h0);
            tick();
            if (i == 1) rst[1] = 1'b0;
        end
        req[1][0] = 1'b1; we[1][0] = 1'b1; addr[1][0] = 32'h80; wdata[1][0] = 32'h0000_A5A5;
        #2;
        chk("t5_post_gnt", 32'(gnt_o[1]), 32'h1);
        chk("t5_post_we", 32'(rwe_o[1]), 32'h1);
        tick();
        req[1][0] = 1'b0;

        // address aliasing above the RAM word address
        do_reset(0);
        req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 32'h4004; wdata[0][1] = 32'h5;
        #2;
        chk("t6_w_gnt", 32'(gnt_o[0]), 32'h2);
        chk("t6_w_addr", 32'(ra_o[0]), 32'h1);
        tick();
        req[0][1] = 1'b0; req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 32'h4;
        #2;
        chk("t6_r_gnt", 32'(gnt_o[0]), 32'h1);
        chk("t6_r_addr", 32'(ra_o[0]), 32'h1);
        tick();
        req[0][0] = 1'b0;
        #2;
        chk("t6_rvalid", 32'(rv_o[0]), 32'h1);
        chk("t6_rdata", rd_o[0][0], 32'h5);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
